// File: rtl/seg7_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_pkg : segment bit positions and the active-high hex font table      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package seg7_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   // Entry n is the lit-segment set for hex digit n, bit SEG_A..SEG_G, 1 = lit.
   localparam logic [15:0][6:0] FONT = '{
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h67, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_hex_decode : combinational nibble to active-high 7-segment pattern  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] pattern_o
);

   assign pattern_o = FONT[nibble_i];

endmodule
`default_nettype wire

// File: rtl/seg7_scan_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_scan_mux : multiplexed N-digit 7-segment driver with frame-latched  |
// |                 data, leading-zero blanking, decimal points and PWM       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module seg7_scan_mux
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int DIV_W          = 20,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit EN_ACTIVE_LOW  = 1'b1
)(
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz_in,
   input  logic [DIV_W-1:0]        clk_divide_in,
   input  logic [3:0]              bright_in,
   output logic [6:0]              segs_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   enables_out,
   output logic                    frame_out
);

   localparam int                    IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [6:0]            SEG_XOR  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic                  DP_XOR   = SEG_ACTIVE_LOW;
   localparam logic [NUM_DIGITS-1:0] EN_XOR   = EN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                              : {NUM_DIGITS{1'b0}};

   logic [DIV_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [3:0]              pwm_q, pwm_d;
   logic [4*NUM_DIGITS-1:0] data_sh_q, data_sh_d;
   logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
   logic                    blz_sh_q, blz_sh_d;
   logic                    frame_q;
   logic [6:0]              segs_q, segs_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   en_q, en_d;

   logic [DIV_W-1:0]        div_last;
   logic                    tick;
   logic                    frame_tick;

   logic                    lz_run;
   logic [NUM_DIGITS-1:0]   blank_vec;
   logic [NUM_DIGITS-1:0]   onehot;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_blank;
   logic [6:0]              pattern;

   // Prescaler, digit index and frame latch. The >= compare recovers at once
   // when the divide value is lowered below the running count.
   always_comb begin
      div_last   = (clk_divide_in == '0) ? '0 : clk_divide_in - DIV_W'(1);
      tick       = (cnt_q >= div_last);
      frame_tick = tick && (idx_q == LAST_IDX);
      cnt_d      = tick ? '0 : cnt_q + DIV_W'(1);
      idx_d      = idx_q;
      if (tick) begin
         idx_d = frame_tick ? '0 : idx_q + IDX_W'(1);
      end
      pwm_d      = pwm_q + 4'd1;
      data_sh_d  = frame_tick ? data_in     : data_sh_q;
      dp_sh_d    = frame_tick ? dp_in       : dp_sh_q;
      blz_sh_d   = frame_tick ? blank_lz_in : blz_sh_q;
   end

   // Blanking walks down from the most significant digit while nibbles are zero.
   always_comb begin
      lz_run    = 1'b1;
      blank_vec = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         lz_run = lz_run & (data_sh_q[4*i +: 4] == 4'h0);
         if (i > 0) begin
            blank_vec[i] = blz_sh_q & lz_run;
         end
      end
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      onehot    = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_nib   = data_sh_q[4*i +: 4];
            cur_dp    = dp_sh_q[i];
            cur_blank = blank_vec[i];
            onehot[i] = 1'b1;
         end
      end
   end

   seg7_hex_decode u_decode (
      .nibble_i  (cur_nib),
      .pattern_o (pattern)
   );

   always_comb begin
      segs_d = (cur_blank ? 7'h00 : pattern) ^ SEG_XOR;
      dp_d   = (cur_dp & ~cur_blank) ^ DP_XOR;
      en_d   = ((!cur_blank && (pwm_q <= bright_in)) ? onehot : '0) ^ EN_XOR;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cnt_q     <= '0;
         idx_q     <= '0;
         pwm_q     <= '0;
         data_sh_q <= '0;
         dp_sh_q   <= '0;
         blz_sh_q  <= 1'b0;
         frame_q   <= 1'b0;
         segs_q    <= SEG_XOR;
         dp_q      <= DP_XOR;
         en_q      <= EN_XOR;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         pwm_q     <= pwm_d;
         data_sh_q <= data_sh_d;
         dp_sh_q   <= dp_sh_d;
         blz_sh_q  <= blz_sh_d;
         frame_q   <= frame_tick;
         segs_q    <= segs_d;
         dp_q      <= dp_d;
         en_q      <= en_d;
      end
   end

   assign segs_out    = segs_q;
   assign dp_out      = dp_q;
   assign enables_out = en_q;
   assign frame_out   = frame_q;

endmodule
`default_nettype wire
